// File: rtl/conv_bias_relu_new.sv
// Per-channel bias add, saturation and optional ReLU on the summed conv
// partial-sum stream; biases are serially preloaded after reset.
module conv_bias_relu_new #(
   parameter int DATA_WIDTH      = 32,
   parameter int FRAC_WIDTH      = 16,
   parameter int IMAGE_WIDTH     = 612,
   parameter int IMAGE_HEIGHT    = 612,
   parameter int CHANNEL_NUM_OUT = 64,
   parameter bit RELU_EN         = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stride2,
   input  logic                  valid_bias_in,
   input  logic [DATA_WIDTH-1:0] bias_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  bias_ready,
   output logic                  frame_done,
   output logic                  err_drop
);

   localparam int CH_W     = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam int PIX_FULL = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int PIX_HALF = (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);
   localparam int PIX_W    = (PIX_FULL > 1) ? $clog2(PIX_FULL) : 1;

   localparam logic [CH_W-1:0]  CH_LAST        = CH_W'(CHANNEL_NUM_OUT - 1);
   localparam logic [PIX_W-1:0] PIX_FULL_LAST  = PIX_W'(PIX_FULL - 1);
   localparam logic [PIX_W-1:0] PIX_HALF_LAST  = PIX_W'(PIX_HALF - 1);

   typedef enum logic {LOAD, RUN} state_t;

   state_t                 state_reg, state_next;
   logic [DATA_WIDTH-1:0]  bias_mem [CHANNEL_NUM_OUT];
   logic [CH_W-1:0]        wptr_reg;
   logic [CH_W-1:0]        ch_cnt_reg;
   logic [PIX_W-1:0]       pix_cnt_reg;
   logic                   stride_reg;
   logic                   err_drop_reg;

   logic [DATA_WIDTH:0]    s1_sum_reg;
   logic                   s1_valid_reg;
   logic                   s1_fd_reg;
   logic [DATA_WIDTH-1:0]  pxl_out_reg;
   logic                   valid_out_reg;
   logic                   frame_done_reg;

   logic                   bias_we;
   logic                   accept;
   logic                   drop;
   logic                   frame_start;
   logic                   stride_cur;
   logic                   ch_last;
   logic                   pix_last;
   logic                   word_last;
   logic [DATA_WIDTH-1:0]  bias_sel;
   logic [DATA_WIDTH:0]    sum_next;
   logic [DATA_WIDTH-1:0]  sat_val;
   logic [DATA_WIDTH-1:0]  act_val;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD: if (valid_bias_in && (wptr_reg == CH_LAST)) state_next = RUN;
         RUN:  state_next = RUN;
         default: state_next = LOAD;
      endcase
   end

   assign bias_we = valid_bias_in && (state_reg == LOAD);
   assign accept  = valid_in && (state_reg == RUN);
   assign drop    = valid_in && (state_reg == LOAD);

   // The first word of a frame uses the live stride2, later words the latched copy.
   assign frame_start = (pix_cnt_reg == '0) && (ch_cnt_reg == '0);
   assign stride_cur  = frame_start ? stride2 : stride_reg;
   assign ch_last     = (ch_cnt_reg == CH_LAST);
   assign pix_last    = stride_cur ? (pix_cnt_reg == PIX_HALF_LAST)
                                   : (pix_cnt_reg == PIX_FULL_LAST);
   assign word_last   = ch_last && pix_last;

   assign bias_sel = bias_mem[ch_cnt_reg];
   assign sum_next = {pxl_in[DATA_WIDTH-1], pxl_in} + {bias_sel[DATA_WIDTH-1], bias_sel};

   // Overflow shows as disagreement between the extra sign bit and the MSB.
   always_comb begin
      sat_val = s1_sum_reg[DATA_WIDTH-1:0];
      if (s1_sum_reg[DATA_WIDTH] != s1_sum_reg[DATA_WIDTH-1]) begin
         sat_val = s1_sum_reg[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      act_val = sat_val;
      if (RELU_EN && sat_val[DATA_WIDTH-1]) act_val = '0;
   end

   always_ff @(posedge clk) begin
      if (bias_we) bias_mem[wptr_reg] <= bias_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= LOAD;
         wptr_reg     <= '0;
         ch_cnt_reg   <= '0;
         pix_cnt_reg  <= '0;
         stride_reg   <= 1'b0;
         err_drop_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (bias_we) wptr_reg <= wptr_reg + 1'b1;
         if (drop) err_drop_reg <= 1'b1;
         if (accept) begin
            if (frame_start) stride_reg <= stride2;
            if (word_last) begin
               ch_cnt_reg  <= '0;
               pix_cnt_reg <= '0;
            end else if (ch_last) begin
               ch_cnt_reg  <= '0;
               pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end else begin
               ch_cnt_reg <= ch_cnt_reg + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sum_reg     <= '0;
         s1_valid_reg   <= 1'b0;
         s1_fd_reg      <= 1'b0;
         pxl_out_reg    <= '0;
         valid_out_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         s1_valid_reg   <= accept;
         s1_fd_reg      <= accept && word_last;
         if (accept) s1_sum_reg <= sum_next;
         valid_out_reg  <= s1_valid_reg;
         frame_done_reg <= s1_fd_reg;
         if (s1_valid_reg) pxl_out_reg <= act_val;
      end
   end

   assign pxl_out    = pxl_out_reg;
   assign valid_out  = valid_out_reg;
   assign frame_done = frame_done_reg;
   assign bias_ready = (state_reg == RUN);
   assign err_drop   = err_drop_reg;

endmodule

// File: tb/tb_conv_bias_relu_new.sv
// Bench for conv_bias_relu_new: a ReLU and a non-ReLU instance share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_conv_bias_relu_new;

   localparam int DW   = 16;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int CH   = 4;
   localparam int NCYC = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stride2 = 1'b0;
   logic          valid_bias_in = 1'b0;
   logic [DW-1:0] bias_in = '0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] pxl_in = '0;

   logic [DW-1:0] pxl_out_r, pxl_out_n;
   logic          valid_out_r, valid_out_n;
   logic          bias_ready_r, bias_ready_n;
   logic          frame_done_r, frame_done_n;
   logic          err_drop_r, err_drop_n;

   conv_bias_relu_new #(.DATA_WIDTH(DW), .FRAC_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                        .CHANNEL_NUM_OUT(CH), .RELU_EN(1'b1)) dut_r (
      .clk(clk), .reset(reset), .stride2(stride2), .valid_bias_in(valid_bias_in),
      .bias_in(bias_in), .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out_r),
      .valid_out(valid_out_r), .bias_ready(bias_ready_r), .frame_done(frame_done_r),
      .err_drop(err_drop_r));

   conv_bias_relu_new #(.DATA_WIDTH(DW), .FRAC_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                        .CHANNEL_NUM_OUT(CH), .RELU_EN(1'b0)) dut_n (
      .clk(clk), .reset(reset), .stride2(stride2), .valid_bias_in(valid_bias_in),
      .bias_in(bias_in), .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out_n),
      .valid_out(valid_out_n), .bias_ready(bias_ready_n), .frame_done(frame_done_n),
      .err_drop(err_drop_n));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   bit            exp_v   [NCYC];
   logic [DW-1:0] exp_dr  [NCYC];
   logic [DW-1:0] exp_dn  [NCYC];
   bit            exp_fd  [NCYC];
   bit            exp_rdy [NCYC];
   bit            exp_err [NCYC];

   int m_bias [CH];
   bit m_loaded;
   int m_wptr;
   bit m_err;
   int m_wc;
   int m_flen;

   function automatic logic [DW-1:0] act(input int s, input bit relu);
      int r;
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return r[DW-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, actual, expected);
      end
   endtask

   // One clock of stimulus; the model fills in what the outputs must show later.
   task automatic tick(input bit rst, input bit vb, input logic [DW-1:0] b,
                       input bit vi, input logic [DW-1:0] p, input bit s2);
      int k, ch, s;
      k = cyc;
      if (k + 2 >= NCYC) begin
         $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", k, NCYC);
         $fatal(1, "cycle budget exceeded");
      end
      reset = rst; valid_bias_in = vb; bias_in = b; valid_in = vi; pxl_in = p; stride2 = s2;
      exp_v[k+2] = 1'b0;
      exp_fd[k+2] = 1'b0;
      if (rst) begin
         m_loaded = 1'b0; m_wptr = 0; m_err = 1'b0; m_wc = 0;
         exp_v[k+1] = 1'b0;
         exp_fd[k+1] = 1'b0;
      end else if (!m_loaded) begin
         if (vi) m_err = 1'b1;
         if (vb) begin
            m_bias[m_wptr] = int'($signed(b));
            m_wptr++;
            if (m_wptr == CH) m_loaded = 1'b1;
         end
      end else if (vi) begin
         ch = m_wc % CH;
         if (m_wc == 0) m_flen = (s2 ? (W/2)*(H/2) : W*H) * CH;
         s = int'($signed(p)) + m_bias[ch];
         exp_v[k+2]  = 1'b1;
         exp_dr[k+2] = act(s, 1'b1);
         exp_dn[k+2] = act(s, 1'b0);
         exp_fd[k+2] = (m_wc == m_flen - 1);
         m_wc = exp_fd[k+2] ? 0 : m_wc + 1;
      end
      exp_rdy[k+1] = m_loaded;
      exp_err[k+1] = m_err;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid_r", valid_out_r, exp_v[cyc]);
         check("valid_n", valid_out_n, exp_v[cyc]);
         if (exp_v[cyc]) begin
            check("data_r", pxl_out_r, exp_dr[cyc]);
            check("data_n", pxl_out_n, exp_dn[cyc]);
         end
         check("fdone_r", frame_done_r, exp_fd[cyc]);
         check("fdone_n", frame_done_n, exp_fd[cyc]);
         check("ready_r", bias_ready_r, exp_rdy[cyc]);
         check("ready_n", bias_ready_n, exp_rdy[cyc]);
         check("err_r", err_drop_r, exp_err[cyc]);
         check("err_n", err_drop_n, exp_err[cyc]);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] t1_lit [CH] = '{16'h0180, 16'h0000, 16'h0080, 16'h7F80};
   logic [DW-1:0] pat;
   int n;

   initial begin
      @(negedge clk);
      tick(1, 0, '0, 0, '0, 0);
      tick(1, 0, '0, 0, '0, 0);
      chk_en = 1'b1;
      check("rst_pxl", pxl_out_r, 16'h0000);
      check("rst_valid", valid_out_r, 1'b0);
      check("rst_ready", bias_ready_r, 1'b0);
      check("rst_fdone", frame_done_r, 1'b0);
      check("rst_err", err_drop_r, 1'b0);

      // Two biases, two early words (dropped), then the rest; last write carries a word too.
      tick(0, 1, 16'h0100, 0, '0, 0);
      tick(0, 1, 16'hFF00, 0, '0, 0);
      tick(0, 0, '0, 1, 16'h0080, 0);
      tick(0, 0, '0, 1, 16'h0080, 0);
      check("load_err", err_drop_r, 1'b1);
      check("load_notready", bias_ready_r, 1'b0);
      tick(0, 1, 16'h0000, 0, '0, 0);
      tick(0, 1, 16'h7F00, 1, 16'h0080, 0);
      tick(0, 0, '0, 0, '0, 0);
      check("load_ready", bias_ready_r, 1'b1);
      check("load_err_sticky", err_drop_r, 1'b1);
      check("load_no_valid", valid_out_r, 1'b0);

      for (int i = 0; i < W*H*CH; i++) begin
         tick(0, 0, '0, 1, 16'h0080, 0);
         if (i >= 1 && i <= CH) check("t1_ch_r", pxl_out_r, t1_lit[i-1]);
         if (i == 2) check("t1_ch1_n", pxl_out_n, 16'hFF80);
      end
      tick(0, 0, '0, 0, '0, 0);
      check("t1_last_fdone", frame_done_r, 1'b1);
      check("t1_last_data", pxl_out_r, 16'h7F80);
      tick(0, 0, '0, 0, '0, 0);
      check("t1_fdone_drop", frame_done_r, 1'b0);

      // Stride-2 frame with stride2 wiggling after word 0.
      for (int j = 0; j < (W/2)*(H/2)*CH; j++) begin
         pat = ((j % CH) == 3) ? 16'h7F00 : ((j % CH) == 0 ? 16'hF000 : 16'h1234);
         tick(0, 0, '0, 1, pat, (j == 0) ? 1'b1 : 1'((j / 2) % 2));
         if (j == 4) check("sat_pos_r", pxl_out_r, 16'h7FFF);
         if (j == 5) check("relu_neg_r", pxl_out_r, 16'h0000);
      end

      // Two back-to-back full frames with random gaps and data.
      n = 0;
      while (n < 2*W*H*CH) begin
         if (n != 0 && $urandom_range(0, 2) == 0) begin
            tick(0, 0, '0, 0, 16'($urandom), 1'($urandom_range(0, 1)));
         end else begin
            tick(0, 0, '0, 1, 16'($urandom),
                 ((n % (W*H*CH)) == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (n == 0) check("s2_frame_done", frame_done_r, 1'b1);
            n++;
         end
      end
      repeat (3) tick(0, 0, '0, 0, '0, 0);

      // Reset with two words in flight, then reload and stream again.
      tick(0, 0, '0, 1, 16'h0100, 0);
      tick(0, 0, '0, 1, 16'h0200, 0);
      tick(1, 0, '0, 0, '0, 0);
      check("mid_rst_valid", valid_out_r, 1'b0);
      check("mid_rst_pxl", pxl_out_r, 16'h0000);
      check("mid_rst_ready", bias_ready_r, 1'b0);
      check("mid_rst_err", err_drop_r, 1'b0);
      tick(0, 0, '0, 0, '0, 0);
      check("mid_rst_valid2", valid_out_n, 1'b0);
      tick(0, 1, 16'h8100, 0, '0, 0);
      tick(0, 1, 16'h8000, 0, '0, 0);
      tick(0, 1, 16'h7FFF, 0, '0, 0);
      tick(0, 1, 16'h0000, 0, '0, 0);
      for (int i = 0; i < (W/2)*(H/2)*CH; i++) begin
         case (i % CH)
            0: pat = 16'h8100;
            1: pat = 16'h8000;
            2: pat = 16'h0001;
            default: pat = 16'h1234;
         endcase
         tick(0, 0, '0, 1, pat, 1'b1);
         if (i == 1) begin
            check("sat_neg_n", pxl_out_n, 16'h8000);
            check("sat_neg_r", pxl_out_r, 16'h0000);
         end
         if (i == 2) check("sat_neg2_n", pxl_out_n, 16'h8000);
         if (i == 3) check("sat_pos2_n", pxl_out_n, 16'h7FFF);
      end
      repeat (3) tick(0, 0, '0, 0, '0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
